reg_dump_streamer: RTL and testbench
====================================

REG_DUMP_STREAMER -- requirements
Module: reg_dump_streamer

Interface
REQ-001 Parameter NUM_REGS, default 32, number of architectural registers captured and streamed.
REQ-002 Parameter SKIP_X0, default 1, when 1 index 0 (hardwired zero) is not streamed.
REQ-003 clk  input  1  single system clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request one dump of the register file; sampled in IDLE only.
REQ-006 regs_flat  input  32*NUM_REGS  concatenated datapath register outputs, register i at bits [32*i+31:32*i].
REQ-007 dout_valid  output  1  stream word available.
REQ-008 dout_ready  input  1  consumer accepts word; transfer when dout_valid and dout_ready both high at a rising edge.
REQ-009 dout_data  output  32  captured value of register dout_idx.
REQ-010 dout_idx  output  5  register index of current word.
REQ-011 dout_last  output  1  high with the final word of a dump.
REQ-012 busy  output  1  high from the cycle after start is accepted until done pulses.
REQ-013 done  output  1  one-cycle pulse after the final transfer.

Function
REQ-014 FSM states IDLE, SEND, DONE; IDLE->SEND on start, SEND->DONE on transfer with dout_last, DONE->IDLE unconditionally after one cycle.
REQ-015 On the edge where start is accepted, all NUM_REGS words of regs_flat SHALL be snapshotted; later regs_flat changes SHALL NOT affect the dump.
REQ-016 Latency: start high at edge N -> dout_valid high in the cycle after edge N, first index = 1 if SKIP_X0 else 0.
REQ-017 Index SHALL increment by one per transfer; final index NUM_REGS-1, no wrap-around to 0.
REQ-018 While dout_valid high and dout_ready low, dout_data, dout_idx, dout_last SHALL hold stable.
REQ-019 dout_valid SHALL stay high in SEND back-to-back; one word per cycle when dout_ready is held high.
REQ-020 dout_valid, dout_last SHALL be low in IDLE and DONE; dout_data/dout_idx SHALL be 0 outside SEND.
REQ-021 start during SEND or DONE SHALL be ignored (not queued).
REQ-022 start held high continuously SHALL produce a new dump on each return to IDLE (one IDLE cycle between dumps).
REQ-023 dout_ready high while dout_valid low SHALL have no effect.

Reset
REQ-024 rst high SHALL immediately force IDLE, index 0, and all outputs (dout_valid, dout_data, dout_idx, dout_last, busy, done) to 0, including mid-dump.
REQ-025 Snapshot buffer contents after reset are don't-care; no partial dump SHALL resume after rst deasserts.

Structure
REQ-026 State encodings and NUM_REGS default SHALL live in the shared datapath include file, also used by the register file.
REQ-027 Snapshot storage SHALL be a sub-module reg_snapshot (NUM_REGS x 32 capture registers with load enable and indexed read port).
REQ-028 Index counter and FSM SHALL reside in reg_dump_streamer.

Verification
REQ-029 regs_flat reg i = i*3, SKIP_X0=1, ready held high, start pulse -> 31 transfers idx 1..31, data 3..93, dout_last with idx 31, done one cycle later.
REQ-030 SKIP_X0=0, ready toggles 1/0 each cycle -> 32 transfers idx 0..31, data stable during every ready-low cycle.
REQ-031 Start dump, then change regs_flat to all 32'hFFFFFFFF on next cycle -> streamed data equals original values.
REQ-032 Assert rst while dout_idx=10 -> same cycle all outputs 0; after release no valid until new start.
REQ-033 Pulse start during SEND at idx 5 -> ignored, exactly one dump completes, one done pulse.
REQ-034 start held high, ready high -> consecutive dumps separated by DONE plus one IDLE cycle, busy low exactly in those cycles.

Source files
------------

// File: rtl/reg_dump_streamer_pkg.sv
// Shared datapath definitions: register-file size and dump FSM states.
// Used by the register file and the dump streamer.
package reg_dump_streamer_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } dump_state_e;

endpackage

// File: rtl/reg_snapshot.sv
// Capture registers for a register-file dump.
// All words load together; one word is read by index.
module reg_snapshot
  import reg_dump_streamer_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic                       clk,
  input  logic                       load,
  input  logic [WORD_W*NUM_REGS-1:0] regs_flat,
  input  logic [4:0]                 rd_idx,
  output logic [WORD_W-1:0]          rd_data
);

  // Contents are don't-care after reset, so no reset term.
  logic [WORD_W-1:0] mem_q [NUM_REGS];

  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= regs_flat[WORD_W*i +: WORD_W];
      end
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/reg_dump_streamer.sv
// Snapshots the register file on start and streams it out
// one word per accepted transfer with index and last flag.
module reg_dump_streamer
  import reg_dump_streamer_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter bit SKIP_X0  = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WORD_W*NUM_REGS-1:0] regs_flat,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [WORD_W-1:0]          dout_data,
  output logic [4:0]                 dout_idx,
  output logic                       dout_last,
  output logic                       busy,
  output logic                       done
);

  localparam logic [4:0] FIRST_IDX = SKIP_X0 ? 5'd1 : 5'd0;
  localparam logic [4:0] LAST_IDX  = 5'(NUM_REGS - 1);

  dump_state_e       state_q;
  dump_state_e       state_d;
  logic [4:0]        idx_q;
  logic              load;
  logic              xfer;
  logic              at_last;
  logic [WORD_W-1:0] rd_data;

  reg_snapshot #(
    .NUM_REGS (NUM_REGS)
  ) u_snap (
    .clk       (clk),
    .load      (load),
    .regs_flat (regs_flat),
    .rd_idx    (idx_q),
    .rd_data   (rd_data)
  );

  assign at_last = (idx_q == LAST_IDX);
  assign xfer    = (state_q == ST_SEND) && dout_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
    end else if (load) begin
      idx_q <= FIRST_IDX;
    end else if (xfer && !at_last) begin
      idx_q <= idx_q + 5'd1;
    end else if (state_q == ST_DONE) begin
      idx_q <= '0;
    end
  end

  // Outputs decode from state so reset clears them at once.
  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    dout_valid = 1'b0;
    dout_data  = '0;
    dout_idx   = '0;
    dout_last  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        dout_valid = 1'b1;
        dout_data  = rd_data;
        dout_idx   = idx_q;
        dout_last  = at_last;
        busy       = 1'b1;
        if (dout_ready && at_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_reg_dump_streamer.sv
// Bench for reg_dump_streamer: two instances (x0 skipped / not
// skipped) checked against an array snapshot model.
module tb_reg_dump_streamer;

  localparam int N = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [32*N-1:0] regs_flat = '0;
  logic           start1 = 1'b0;
  logic           ready1 = 1'b0;
  logic           start0 = 1'b0;
  logic           ready0 = 1'b0;

  logic        v1, l1, b1, dn1;
  logic        v0, l0, b0, dn0;
  logic [31:0] d1, d0;
  logic [4:0]  i1, i0;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] snap [N];

  always #5 clk = ~clk;

  reg_dump_streamer #(.NUM_REGS(N), .SKIP_X0(1'b1)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .start      (start1),
    .regs_flat  (regs_flat),
    .dout_valid (v1),
    .dout_ready (ready1),
    .dout_data  (d1),
    .dout_idx   (i1),
    .dout_last  (l1),
    .busy       (b1),
    .done       (dn1)
  );

  reg_dump_streamer #(.NUM_REGS(N), .SKIP_X0(1'b0)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .start      (start0),
    .regs_flat  (regs_flat),
    .dout_valid (v0),
    .dout_ready (ready0),
    .dout_data  (d0),
    .dout_idx   (i0),
    .dout_last  (l0),
    .busy       (b0),
    .done       (dn0)
  );

  task automatic load_regs(input bit rnd);
    for (int i = 0; i < N; i++) begin
      snap[i] = rnd ? 32'($urandom) : 32'(i * 3);
      regs_flat[32*i +: 32] = snap[i];
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({v1, l1, b1, dn1, i1, d1} !== '0) begin
      n_err++;
      $display("FAIL reset_dut1: got v=%b l=%b b=%b d=%b idx=%0d data=%h, want all 0",
               v1, l1, b1, dn1, i1, d1);
    end
    n_cmp++;
    if ({v0, l0, b0, dn0, i0, d0} !== '0) begin
      n_err++;
      $display("FAIL reset_dut0: got v=%b l=%b b=%b d=%b idx=%0d data=%h, want all 0",
               v0, l0, b0, dn0, i0, d0);
    end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({v1, b1, v0, b0} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_idle: got v1=%b b1=%b v0=%b b0=%b, want 0", v1, b1, v0, b0);
    end
  endtask

  task automatic test_basic();
    load_regs(1'b0);
    @(negedge clk);
    start1 = 1'b1;
    ready1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int k = 1; k < N; k++) begin
      n_cmp++;
      if ({v1, b1, l1, i1, d1} !== {1'b1, 1'b1, (k == N - 1), 5'(k), snap[k]}) begin
        n_err++;
        $display("FAIL basic_word k=%0d: got v=%b b=%b last=%b idx=%0d data=%h, want idx=%0d data=%h",
                 k, v1, b1, l1, i1, d1, k, snap[k]);
      end
      @(negedge clk);
    end
    n_cmp++;
    if ({v1, b1, dn1, l1, i1, d1} !== {3'b001, 1'b0, 5'd0, 32'd0}) begin
      n_err++;
      $display("FAIL basic_done: got v=%b b=%b done=%b idx=%0d data=%h, want done only",
               v1, b1, dn1, i1, d1);
    end
    @(negedge clk);
    n_cmp++;
    if ({v1, b1, dn1} !== 3'b000) begin
      n_err++;
      $display("FAIL basic_idle: got v=%b b=%b done=%b, want 000", v1, b1, dn1);
    end
    ready1 = 1'b0;
  endtask

  task automatic test_snapshot();
    int  exp_idx;
    int  xfers;
    bit  got_done;
    load_regs(1'b1);
    @(negedge clk);
    start1 = 1'b1;
    ready1 = 1'($urandom % 2);
    @(negedge clk);
    start1 = 1'b0;
    regs_flat = '1;
    exp_idx = 1;
    xfers = 0;
    got_done = 1'b0;
    for (int c = 0; c < 400 && !got_done; c++) begin
      if (dn1) begin
        got_done = 1'b1;
        n_cmp++;
        if (xfers != N - 1) begin
          n_err++;
          $display("FAIL snap_count: got %0d transfers, want %0d", xfers, N - 1);
        end
      end else begin
        n_cmp++;
        if ({v1, i1, d1, l1} !== {1'b1, 5'(exp_idx), snap[exp_idx % N], (exp_idx == N - 1)}) begin
          n_err++;
          $display("FAIL snap_word: got v=%b idx=%0d data=%h last=%b, want idx=%0d data=%h",
                   v1, i1, d1, l1, exp_idx, snap[exp_idx % N]);
        end
        ready1 = 1'($urandom % 2);
        if (v1 && ready1) begin
          xfers++;
          exp_idx++;
        end
        @(negedge clk);
      end
    end
    if (!got_done) begin
      n_cmp++;
      n_err++;
      $display("FAIL snap_timeout: got no done, want done");
    end
    ready1 = 1'b0;
  endtask

  task automatic test_stable();
    int          exp_idx;
    int          xfers;
    bit          got_done;
    bit          held;
    logic [37:0] prev;
    load_regs(1'b1);
    @(negedge clk);
    start0 = 1'b1;
    ready0 = 1'b0;
    @(negedge clk);
    start0 = 1'b0;
    exp_idx = 0;
    xfers = 0;
    got_done = 1'b0;
    held = 1'b0;
    prev = '0;
    for (int c = 0; c < 200 && !got_done; c++) begin
      if (dn0) begin
        got_done = 1'b1;
        n_cmp++;
        if (xfers != N) begin
          n_err++;
          $display("FAIL stable_count: got %0d transfers, want %0d", xfers, N);
        end
      end else begin
        n_cmp++;
        if ({v0, i0, d0, l0} !== {1'b1, 5'(exp_idx), snap[exp_idx % N], (exp_idx == N - 1)}) begin
          n_err++;
          $display("FAIL stable_word: got v=%b idx=%0d data=%h last=%b, want idx=%0d data=%h",
                   v0, i0, d0, l0, exp_idx, snap[exp_idx % N]);
        end
        if (held) begin
          n_cmp++;
          if ({i0, d0, l0} !== prev) begin
            n_err++;
            $display("FAIL stable_hold: got %h, want %h", {i0, d0, l0}, prev);
          end
        end
        prev = {i0, d0, l0};
        ready0 = ~ready0;
        held = v0 && !ready0;
        if (v0 && ready0) begin
          xfers++;
          exp_idx++;
        end
        @(negedge clk);
      end
    end
    if (!got_done) begin
      n_cmp++;
      n_err++;
      $display("FAIL stable_timeout: got no done, want done");
    end
    ready0 = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found;
    load_regs(1'b0);
    @(negedge clk);
    start1 = 1'b1;
    ready1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (v1 && i1 == 5'd10) found = 1'b1;
      else @(negedge clk);
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL rstmid_reach: got idx=%0d, want idx 10 reached", i1);
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({v1, l1, b1, dn1, i1, d1} !== '0) begin
      n_err++;
      $display("FAIL rstmid_zero: got v=%b l=%b b=%b d=%b idx=%0d data=%h, want all 0",
               v1, l1, b1, dn1, i1, d1);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({v1, b1, dn1} !== 3'b000) begin
        n_err++;
        $display("FAIL rstmid_noresume c=%0d: got v=%b b=%b done=%b, want 000",
                 c, v1, b1, dn1);
      end
    end
    ready1 = 1'b0;
  endtask

  task automatic test_start_ignored();
    int exp_idx;
    int xfers;
    int dones;
    bit pulsed;
    load_regs(1'b1);
    @(negedge clk);
    start1 = 1'b1;
    ready1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    exp_idx = 1;
    xfers = 0;
    dones = 0;
    pulsed = 1'b0;
    for (int c = 0; c < 60; c++) begin
      start1 = 1'b0;
      if (v1) begin
        n_cmp++;
        if ({i1, d1} !== {5'(exp_idx), snap[exp_idx % N]}) begin
          n_err++;
          $display("FAIL ign_word: got idx=%0d data=%h, want idx=%0d data=%h",
                   i1, d1, exp_idx, snap[exp_idx % N]);
        end
        if (i1 == 5'd5 && !pulsed) begin
          start1 = 1'b1;
          pulsed = 1'b1;
        end
        xfers++;
        exp_idx++;
      end
      if (dn1) dones++;
      @(negedge clk);
    end
    start1 = 1'b0;
    n_cmp++;
    if (xfers != N - 1 || dones != 1) begin
      n_err++;
      $display("FAIL ign_count: got %0d transfers %0d done, want %0d and 1",
               xfers, dones, N - 1);
    end
    ready1 = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_ctl;
    logic [4:0] exp_idx;
    load_regs(1'b0);
    @(negedge clk);
    start1 = 1'b1;
    ready1 = 1'b1;
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < N + 1; c++) begin
        @(negedge clk);
        if (c < N - 1) begin
          exp_ctl = 4'b1100;
          exp_idx = 5'(c + 1);
        end else if (c == N - 1) begin
          exp_ctl = 4'b0001;
          exp_idx = 5'd0;
        end else begin
          exp_ctl = 4'b0000;
          exp_idx = 5'd0;
        end
        n_cmp++;
        if ({b1, v1, l1, dn1} !== (exp_ctl | {2'b00, (c == N - 2), 1'b0}) ||
            i1 !== exp_idx) begin
          n_err++;
          $display("FAIL b2b p=%0d c=%0d: got b=%b v=%b l=%b d=%b idx=%0d, want ctl=%b idx=%0d",
                   p, c, b1, v1, l1, dn1, i1, exp_ctl, exp_idx);
        end
        if (p == 2 && c == N) start1 = 1'b0;
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({b1, v1, dn1} !== 3'b000) begin
      n_err++;
      $display("FAIL b2b_stop: got b=%b v=%b d=%b, want 000", b1, v1, dn1);
    end
    ready1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_snapshot();
    test_stable();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
